// File: rtl/list_engine.sv
// Serialised list store: indexed read/insert/delete, key search, summation and clear.
// One command in flight; results are streamed as registered single-cycle beats.
module list_engine #(
  parameter int  DATA_WIDTH = 32,
  parameter int  LENGTH     = 8,
  parameter int  SORTED     = 0,
  localparam int IDX_W      = $clog2(LENGTH),
  localparam int CNT_W      = $clog2(LENGTH + 1),
  localparam int OUT_W      = IDX_W + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op_sel,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [IDX_W-1:0]      index_in,
  output logic                  res_valid,
  output logic                  res_last,
  output logic                  res_error,
  output logic [OUT_W-1:0]      data_out,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [2:0] OP_READ     = 3'b000;
  localparam logic [2:0] OP_INSERT   = 3'b001;
  localparam logic [2:0] OP_FIND_ALL = 3'b010;
  localparam logic [2:0] OP_FIND_1ST = 3'b011;
  localparam logic [2:0] OP_SUM      = 3'b100;
  localparam logic [2:0] OP_DELETE   = 3'b101;
  localparam logic [2:0] OP_CLEAR    = 3'b110;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN_1ST = 3'd1,
    SCAN_ALL = 3'd2,
    ALL_TERM = 3'd3,
    SUM      = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      scan_idx_reg, scan_idx_next;
  logic [OUT_W-1:0]      acc_reg, acc_next;
  logic [CNT_W-1:0]      match_cnt_reg, match_cnt_next;
  logic [DATA_WIDTH-1:0] key_reg, key_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  res_valid_reg, res_valid_next;
  logic                  res_last_reg, res_last_next;
  logic                  res_error_reg, res_error_next;
  logic [OUT_W-1:0]      data_out_reg, data_out_next;

  logic [DATA_WIDTH-1:0] mem_reg  [LENGTH];
  logic [DATA_WIDTH-1:0] mem_next [LENGTH];
  logic [DATA_WIDTH-1:0] ins_val  [LENGTH];
  logic [DATA_WIDTH-1:0] del_val  [LENGTH];

  logic [CNT_W-1:0]      idx_ext;
  logic [CNT_W-1:0]      ins_pos;
  logic                  idx_ok;
  logic                  is_full;
  logic                  is_empty;
  logic [DATA_WIDTH-1:0] cur_entry;
  logic                  scan_last;
  logic                  hit;
  logic [OUT_W-1:0]      acc_sum;

  assign idx_ext   = CNT_W'(index_in);
  assign idx_ok    = idx_ext < count_reg;
  assign is_full   = count_reg == CNT_W'(LENGTH);
  assign is_empty  = count_reg == '0;
  assign cur_entry = mem_reg[scan_idx_reg];
  assign scan_last = CNT_W'(scan_idx_reg) == (count_reg - CNT_W'(1));
  assign hit       = cur_entry == key_reg;
  assign acc_sum   = acc_reg + OUT_W'(cur_entry);

  // Insert slot: sorted mode lands after every stored entry <= data_in, keeping ties stable.
  generate
    if (SORTED != 0) begin : g_sorted
      logic [LENGTH-1:0] le_vec;
      for (genvar gi = 0; gi < LENGTH; gi++) begin : g_le
        localparam logic [CNT_W-1:0] SLOT = CNT_W'(gi);
        assign le_vec[gi] = (SLOT < count_reg) && (mem_reg[gi] <= data_in);
      end
      always_comb begin
        ins_pos = '0;
        for (int i = 0; i < LENGTH; i++) begin
          ins_pos = ins_pos + CNT_W'(le_vec[i]);
        end
      end
    end else begin : g_indexed
      assign ins_pos = idx_ok ? idx_ext : count_reg;
    end
  endgenerate

  // Shifted copies of storage for insert and delete; slots at or above count stay zero.
  generate
    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_slot
      localparam logic [CNT_W-1:0] SLOT = CNT_W'(gi);
      if (gi == 0) begin : g_ins_first
        assign ins_val[gi] = (SLOT == ins_pos) ? data_in : mem_reg[gi];
      end else begin : g_ins_rest
        assign ins_val[gi] = (SLOT < ins_pos)  ? mem_reg[gi] :
                             (SLOT == ins_pos) ? data_in : mem_reg[gi-1];
      end
      if (gi == LENGTH - 1) begin : g_del_last
        assign del_val[gi] = (SLOT < idx_ext) ? mem_reg[gi] : '0;
      end else begin : g_del_rest
        assign del_val[gi] = (SLOT < idx_ext) ? mem_reg[gi] : mem_reg[gi+1];
      end
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    scan_idx_next  = scan_idx_reg;
    acc_next       = acc_reg;
    match_cnt_next = match_cnt_reg;
    key_next       = key_reg;
    count_next     = count_reg;
    mem_next       = mem_reg;
    res_valid_next = 1'b0;
    res_last_next  = 1'b0;
    res_error_next = 1'b0;
    data_out_next  = data_out_reg;

    case (state_reg)
      IDLE: begin
        if (op_valid) begin
          key_next       = data_in;
          scan_idx_next  = '0;
          acc_next       = '0;
          match_cnt_next = '0;
          // Every op except a non-empty scan answers with one beat next cycle.
          res_valid_next = 1'b1;
          res_last_next  = 1'b1;
          data_out_next  = '0;
          case (op_sel)
            OP_READ: begin
              if (idx_ok) data_out_next = OUT_W'(mem_reg[index_in]);
              else        res_error_next = 1'b1;
            end
            OP_INSERT: begin
              if (is_full) begin
                res_error_next = 1'b1;
              end else begin
                mem_next   = ins_val;
                count_next = count_reg + CNT_W'(1);
              end
            end
            OP_FIND_ALL, OP_FIND_1ST: begin
              if (is_empty) begin
                res_error_next = 1'b1;
              end else begin
                res_valid_next = 1'b0;
                res_last_next  = 1'b0;
                state_next     = (op_sel == OP_FIND_ALL) ? SCAN_ALL : SCAN_1ST;
              end
            end
            OP_SUM: begin
              if (!is_empty) begin
                res_valid_next = 1'b0;
                res_last_next  = 1'b0;
                state_next     = SUM;
              end
            end
            OP_DELETE: begin
              if (idx_ok) begin
                mem_next   = del_val;
                count_next = count_reg - CNT_W'(1);
              end else begin
                res_error_next = 1'b1;
              end
            end
            OP_CLEAR: begin
              for (int i = 0; i < LENGTH; i++) mem_next[i] = '0;
              count_next = '0;
            end
            default: res_error_next = 1'b1;
          endcase
        end
      end
      SCAN_1ST: begin
        if (hit) begin
          res_valid_next = 1'b1;
          res_last_next  = 1'b1;
          data_out_next  = OUT_W'(scan_idx_reg);
          state_next     = IDLE;
        end else if (scan_last) begin
          res_valid_next = 1'b1;
          res_last_next  = 1'b1;
          res_error_next = 1'b1;
          data_out_next  = '0;
          state_next     = IDLE;
        end else begin
          scan_idx_next = scan_idx_reg + IDX_W'(1);
        end
      end
      SCAN_ALL: begin
        if (hit) begin
          res_valid_next = 1'b1;
          data_out_next  = OUT_W'(scan_idx_reg);
          match_cnt_next = match_cnt_reg + CNT_W'(1);
        end
        if (scan_last) state_next    = ALL_TERM;
        else           scan_idx_next = scan_idx_reg + IDX_W'(1);
      end
      ALL_TERM: begin
        res_valid_next = 1'b1;
        res_last_next  = 1'b1;
        res_error_next = match_cnt_reg == '0;
        data_out_next  = OUT_W'(match_cnt_reg);
        state_next     = IDLE;
      end
      SUM: begin
        if (scan_last) begin
          res_valid_next = 1'b1;
          res_last_next  = 1'b1;
          data_out_next  = acc_sum;
          state_next     = IDLE;
        end else begin
          acc_next      = acc_sum;
          scan_idx_next = scan_idx_reg + IDX_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      scan_idx_reg  <= '0;
      acc_reg       <= '0;
      match_cnt_reg <= '0;
      key_reg       <= '0;
      count_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_last_reg  <= 1'b0;
      res_error_reg <= 1'b0;
      data_out_reg  <= '0;
      for (int i = 0; i < LENGTH; i++) mem_reg[i] <= '0;
    end else begin
      state_reg     <= state_next;
      scan_idx_reg  <= scan_idx_next;
      acc_reg       <= acc_next;
      match_cnt_reg <= match_cnt_next;
      key_reg       <= key_next;
      count_reg     <= count_next;
      res_valid_reg <= res_valid_next;
      res_last_reg  <= res_last_next;
      res_error_reg <= res_error_next;
      data_out_reg  <= data_out_next;
      mem_reg       <= mem_next;
    end
  end

  assign op_ready  = state_reg == IDLE;
  assign res_valid = res_valid_reg;
  assign res_last  = res_last_reg;
  assign res_error = res_error_reg;
  assign data_out  = data_out_reg;
  assign count     = count_reg;
  assign full      = is_full;
  assign empty     = is_empty;

endmodule

// File: tb/tb_list_engine.sv
// Scoreboard bench for list_engine: an indexed instance (a) and a sorted instance (b),
// both LENGTH=4, DATA_WIDTH=8, checked against a queue-based list model with beat timing.
module tb_list_engine;

  localparam int DW = 8;
  localparam int LEN = 4;
  localparam int IW = 2;
  localparam int CW = 3;
  localparam int OW = IW + DW;

  localparam int OP_READ = 0, OP_INS = 1, OP_FALL = 2, OP_F1ST = 3;
  localparam int OP_SUM = 4, OP_DEL = 5, OP_CLR = 6, OP_RSV = 7;

  typedef struct {
    int data;
    bit last;
    bit err;
    int cyc;
    bit chk_data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [2:0]    op_sel = '0;
  logic [DW-1:0] data_in = '0;
  logic [IW-1:0] index_in = '0;
  logic          op_valid_a = 1'b0, op_valid_b = 1'b0;
  logic          op_ready_a, op_ready_b;
  logic          res_valid_a, res_valid_b, res_last_a, res_last_b, res_error_a, res_error_b;
  logic [OW-1:0] data_out_a, data_out_b;
  logic [CW-1:0] count_a, count_b;
  logic          full_a, full_b, empty_a, empty_b;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   mdl_a[$];
  int   mdl_b[$];

  list_engine #(.DATA_WIDTH(DW), .LENGTH(LEN), .SORTED(0)) u_list_a (
    .clk(clk), .rst(rst), .op_valid(op_valid_a), .op_ready(op_ready_a), .op_sel(op_sel),
    .data_in(data_in), .index_in(index_in), .res_valid(res_valid_a), .res_last(res_last_a),
    .res_error(res_error_a), .data_out(data_out_a), .count(count_a), .full(full_a),
    .empty(empty_a));

  list_engine #(.DATA_WIDTH(DW), .LENGTH(LEN), .SORTED(1)) u_list_b (
    .clk(clk), .rst(rst), .op_valid(op_valid_b), .op_ready(op_ready_b), .op_sel(op_sel),
    .data_in(data_in), .index_in(index_in), .res_valid(res_valid_b), .res_last(res_last_b),
    .res_error(res_error_b), .data_out(data_out_b), .count(count_b), .full(full_b),
    .empty(empty_b));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel != 0) ? q_b.size() : q_a.size();
  endfunction

  task automatic push(input int sel, input int data, input bit last, input bit err,
                      input int c, input bit chk_data);
    exp_t e;
    e.data = data; e.last = last; e.err = err; e.cyc = c; e.chk_data = chk_data;
    if (sel != 0) q_b.push_back(e);
    else          q_a.push_back(e);
  endtask

  task automatic compare_beat(input int sel, input int data, input bit last, input bit err);
    exp_t e;
    if (qsize(sel) == 0) begin
      check("unexpected_beat", 1, 0);
    end else begin
      if (sel != 0) e = q_b.pop_front();
      else          e = q_a.pop_front();
      check("beat_cycle", cyc, e.cyc);
      if (e.chk_data) check("beat_data", data, e.data);
      check("beat_last", int'(last), int'(e.last));
      check("beat_error", int'(err), int'(e.err));
    end
  endtask

  always @(negedge clk) begin
    if (res_valid_a) compare_beat(0, int'(data_out_a), res_last_a, res_error_a);
    if (res_valid_b) compare_beat(1, int'(data_out_b), res_last_b, res_error_b);
  end

  // Drive one command at a negedge, predict its beats from the model, accept at the next edge.
  task automatic issue(input int sel, input int op, input int d, input int idx);
    int m[$];
    int n, cnt, pos, sum, first;
    @(negedge clk);
    check("op_ready", int'((sel != 0) ? op_ready_b : op_ready_a), 1);
    n = cyc;
    if (sel != 0) m = mdl_b;
    else          m = mdl_a;
    $display("[TB] dut=%0d op=%0d data=%0d idx=%0d cyc=%0d", sel, op, d, idx, n);
    case (op)
      OP_READ: begin
        if (idx < m.size()) push(sel, m[idx], 1, 0, n + 1, 1);
        else                push(sel, 0, 1, 1, n + 1, 1);
      end
      OP_INS: begin
        if (m.size() == LEN) begin
          push(sel, 0, 1, 1, n + 1, 0);
        end else begin
          if (sel != 0) begin
            pos = 0;
            foreach (m[k]) if (m[k] <= d) pos++;
          end else begin
            pos = (idx >= m.size()) ? m.size() : idx;
          end
          m.insert(pos, d);
          push(sel, 0, 1, 0, n + 1, 1);
        end
      end
      OP_DEL: begin
        if (idx < m.size()) begin
          m.delete(idx);
          push(sel, 0, 1, 0, n + 1, 0);
        end else begin
          push(sel, 0, 1, 1, n + 1, 0);
        end
      end
      OP_CLR: begin
        m.delete();
        push(sel, 0, 1, 0, n + 1, 0);
      end
      OP_FALL: begin
        if (m.size() == 0) begin
          push(sel, 0, 1, 1, n + 1, 1);
        end else begin
          cnt = 0;
          foreach (m[k]) if (m[k] == d) begin push(sel, k, 0, 0, n + 2 + k, 1); cnt++; end
          push(sel, cnt, 1, cnt == 0, n + 2 + m.size(), 1);
        end
      end
      OP_F1ST: begin
        if (m.size() == 0) begin
          push(sel, 0, 1, 1, n + 1, 1);
        end else begin
          first = -1;
          foreach (m[k]) if (first < 0 && m[k] == d) first = k;
          if (first >= 0) push(sel, first, 1, 0, n + 2 + first, 1);
          else            push(sel, 0, 1, 1, n + 1 + m.size(), 0);
        end
      end
      OP_SUM: begin
        sum = 0;
        foreach (m[k]) sum += m[k];
        push(sel, sum, 1, 0, (m.size() == 0) ? n + 1 : n + 1 + m.size(), 1);
      end
      default: push(sel, 0, 1, 1, n + 1, 0);
    endcase
    if (sel != 0) mdl_b = m;
    else          mdl_a = m;
    op_sel   = 3'(op);
    data_in  = DW'(d);
    index_in = IW'(idx);
    if (sel != 0) op_valid_b = 1'b1;
    else          op_valid_a = 1'b1;
    @(posedge clk);
    #1;
    op_valid_a = 1'b0;
    op_valid_b = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    for (int i = 0; i < 40; i++) begin
      if (qsize(sel) == 0) break;
      @(negedge clk);
    end
    check("drain", qsize(sel), 0);
  endtask

  task automatic read_all(input int sel);
    for (int i = 0; i < LEN; i++) issue(sel, OP_READ, 0, i);
    wait_done(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_op_ready", int'(op_ready_a), 1);
    check("rst_count", int'(count_a), 0);
    check("rst_empty", int'(empty_a), 1);
    check("rst_full", int'(full_a), 0);
    check("rst_res_valid", int'(res_valid_a), 0);
    check("rst_res_last", int'(res_last_a), 0);
    check("rst_res_error", int'(res_error_a), 0);
    check("rst_data_out", int'(data_out_a), 0);
    check("rst_count_b", int'(count_b), 0);
    rst = 1'b0;

    // Appends, a mid-list insert, then overflow.
    issue(0, OP_INS, 10, 3);
    issue(0, OP_INS, 20, 3);
    issue(0, OP_INS, 30, 3);
    issue(0, OP_INS, 15, 1);
    read_all(0);
    check("full_after_4", int'(full_a), 1);
    check("count_after_4", int'(count_a), 4);
    issue(0, OP_INS, 99, 0);
    read_all(0);
    check("count_after_ovf", int'(count_a), 4);

    // Delete, delete out of range, clear.
    issue(0, OP_DEL, 0, 0);
    read_all(0);
    check("count_after_del", int'(count_a), 3);
    check("full_after_del", int'(full_a), 0);
    issue(0, OP_DEL, 0, 3);
    issue(0, OP_INS, 40, 3);
    read_all(0);
    issue(0, OP_CLR, 0, 0);
    wait_done(0);
    check("empty_after_clr", int'(empty_a), 1);
    check("count_after_clr", int'(count_a), 0);

    // Searches over {5,7,5,5}, plus the reserved opcode.
    issue(0, OP_INS, 5, 0);
    issue(0, OP_INS, 7, 1);
    issue(0, OP_INS, 5, 2);
    issue(0, OP_INS, 5, 3);
    wait_done(0);
    issue(0, OP_FALL, 5, 0); wait_done(0);
    issue(0, OP_FALL, 9, 0); wait_done(0);
    issue(0, OP_F1ST, 7, 0); wait_done(0);
    issue(0, OP_F1ST, 5, 0); wait_done(0);
    issue(0, OP_F1ST, 9, 0); wait_done(0);
    issue(0, OP_FALL, 7, 0); wait_done(0);
    issue(0, OP_RSV, 0, 0);
    read_all(0);

    // Sums, including the busy window and empty-list scans.
    issue(0, OP_CLR, 0, 0);
    for (int i = 0; i < LEN; i++) issue(0, OP_INS, 255, 3);
    issue(0, OP_SUM, 0, 0);
    @(negedge clk);
    check("busy_op_ready", int'(op_ready_a), 0);
    wait_done(0);
    issue(0, OP_CLR, 0, 0);
    issue(0, OP_SUM, 0, 0);
    issue(0, OP_FALL, 3, 0);
    issue(0, OP_F1ST, 3, 0);
    wait_done(0);

    // Sorted instance ignores index_in.
    issue(1, OP_INS, 30, 0);
    issue(1, OP_INS, 10, 3);
    issue(1, OP_INS, 20, 0);
    issue(1, OP_INS, 10, 1);
    read_all(1);
    issue(1, OP_F1ST, 20, 0); wait_done(1);
    issue(1, OP_SUM, 0, 0); wait_done(1);
    issue(1, OP_DEL, 0, 1);
    issue(1, OP_INS, 15, 0);
    read_all(1);

    // Reset in the middle of FIND_ALL, after its first beat.
    issue(0, OP_INS, 5, 0);
    issue(0, OP_INS, 7, 1);
    issue(0, OP_INS, 5, 2);
    issue(0, OP_INS, 5, 3);
    wait_done(0);
    issue(0, OP_FALL, 5, 0);
    repeat (3) @(negedge clk);
    check("pre_rst_pending", qsize(0), 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_a.delete();
    mdl_a.delete();
    mdl_b.delete();
    @(negedge clk);
    check("post_rst_res_valid", int'(res_valid_a), 0);
    check("post_rst_count", int'(count_a), 0);
    check("post_rst_op_ready", int'(op_ready_a), 1);
    check("post_rst_count_b", int'(count_b), 0);
    repeat (8) @(negedge clk);
    issue(0, OP_READ, 0, 0);
    wait_done(0);

    check("final_queue_a", q_a.size(), 0);
    check("final_queue_b", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
